// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller slice.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

endpackage

// File: rtl/dual_port_ram.sv
// Single-address RAM: synchronous active-high clear, registered read port.
module dual_port_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wr_enb,
  input  logic              rd_enb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (rst) begin
      mem  <= '{default: '0};
      dout <= '0;
    end else begin
      if (wr_enb) mem[addr] <= din;
      if (rd_enb) dout <= mem[addr];
    end
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer flips to the loser after every grant.
module rr_arb2
  import ram_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic prio_b;

  always_comb begin
    gnt = '0;
    if (enable) begin
      if (req[REQ_A] && (!req[REQ_B] || !prio_b)) begin
        gnt[REQ_A] = 1'b1;
      end else if (req[REQ_B]) begin
        gnt[REQ_B] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      prio_b <= 1'b0;
    end else if (|gnt) begin
      prio_b <= gnt[REQ_A];
    end
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Shares one RAM between requesters A and B, sequences RAM clear after reset
// and on command, and returns read data two cycles after the grant.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_ack,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_rst,
  output logic              ram_wr_enb,
  output logic              ram_rd_enb,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              any_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              tag_vld;
  logic              tag_own_b;

  always_comb begin
    req        = '0;
    req[REQ_A] = req_a;
    req[REQ_B] = req_b;
  end

  assign arb_en  = (state == RUN) && !clr_req;
  assign any_gnt = |gnt;

  rr_arb2 u_arb (
    .clock  (clock),
    .rst_n  (rst_n),
    .req    (req),
    .enable (arb_en),
    .gnt    (gnt)
  );

  always_comb begin
    win_we    = we_a;
    win_addr  = addr_a;
    win_wdata = wdata_a;
    if (gnt[REQ_B]) begin
      win_we    = we_b;
      win_addr  = addr_b;
      win_wdata = wdata_b;
    end
  end

  assign gnt_a   = gnt[REQ_A];
  assign gnt_b   = gnt[REQ_B];
  assign clr_ack = (state == CLEAR);
  assign rdata   = ram_dout;

  // ram_rst is set from the state being entered, so the RAM clears on the
  // edge that ends the INIT or CLEAR cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      ram_rst    <= 1'b1;
      ram_wr_enb <= 1'b0;
      ram_rd_enb <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      tag_vld    <= 1'b0;
      tag_own_b  <= 1'b0;
      rvalid_a   <= 1'b0;
      rvalid_b   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          state   <= RUN;
          ram_rst <= 1'b0;
        end
        RUN: begin
          state   <= clr_req ? CLEAR : RUN;
          ram_rst <= clr_req;
        end
        CLEAR: begin
          state   <= RUN;
          ram_rst <= 1'b0;
        end
        default: begin
          state   <= INIT;
          ram_rst <= 1'b1;
        end
      endcase

      ram_wr_enb <= any_gnt && win_we;
      ram_rd_enb <= any_gnt && !win_we;
      if (any_gnt) begin
        ram_addr <= win_addr;
        ram_din  <= win_wdata;
      end

      tag_vld   <= any_gnt && !win_we;
      tag_own_b <= gnt[REQ_B];
      rvalid_a  <= tag_vld && !tag_own_b;
      rvalid_b  <= tag_vld && tag_own_b;
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed scenarios followed by random traffic, checked against a
// transaction-order model of arbitration, memory contents and read returns.
module tb_ram_access_ctrl;
  import ram_ctrl_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr_req = 1'b0;
  logic          clr_ack;
  logic          req_a = 1'b0, req_b = 1'b0;
  logic          we_a = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [DW-1:0] rdata;
  logic          ram_rst, ram_wr_enb, ram_rd_enb;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  always #5 clock = ~clock;

  ram_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .clr_ack    (clr_ack),
    .req_a      (req_a),
    .req_b      (req_b),
    .we_a       (we_a),
    .we_b       (we_b),
    .addr_a     (addr_a),
    .addr_b     (addr_b),
    .wdata_a    (wdata_a),
    .wdata_b    (wdata_b),
    .gnt_a      (gnt_a),
    .gnt_b      (gnt_b),
    .rvalid_a   (rvalid_a),
    .rvalid_b   (rvalid_b),
    .rdata      (rdata),
    .ram_rst    (ram_rst),
    .ram_wr_enb (ram_wr_enb),
    .ram_rd_enb (ram_rd_enb),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
  );

  dual_port_ram #(.DATA_W(DW), .ADDR_W(AW)) u_ram (
    .clock  (clock),
    .rst    (ram_rst),
    .wr_enb (ram_wr_enb),
    .rd_enb (ram_rd_enb),
    .addr   (ram_addr),
    .din    (ram_din),
    .dout   (ram_dout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model: every access takes effect in grant order, so the value a read
  // returns is simply the model memory at grant time.
  typedef struct {
    int            due;
    int            own;
    logic [DW-1:0] data;
  } rd_t;

  logic [DW-1:0] mem_m [2**AW];
  rd_t           rdq [$];
  bit            in_init, in_clear;
  int            last_win;
  int            cyc;
  bit   [1:0]    exp_g;
  bit            p_wr, p_rd;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_din;

  function automatic void model_reset();
    foreach (mem_m[i]) mem_m[i] = '0;
    rdq.delete();
    in_init  = 1'b1;
    in_clear = 1'b0;
    last_win = 1;
    cyc      = 0;
    exp_g    = '0;
    p_wr     = 1'b0;
    p_rd     = 1'b0;
    p_addr   = '0;
    p_din    = '0;
  endfunction

  task automatic cycle();
    int            w;
    bit            t_we;
    logic [AW-1:0] t_ad;
    logic [DW-1:0] t_wd;
    rd_t           r;
    @(negedge clock);
    w = -1;
    if (!in_init && !in_clear && !clr_req) begin
      if (req_a && req_b) w = 1 - last_win;
      else if (req_a)     w = 0;
      else if (req_b)     w = 1;
    end
    check_eq("gnt_a", gnt_a, w == 0);
    check_eq("gnt_b", gnt_b, w == 1);
    check_eq("clr_ack", clr_ack, in_clear);
    check_eq("ram_rst", ram_rst, in_init || in_clear);
    check_eq("ram_wr_enb", ram_wr_enb, p_wr);
    check_eq("ram_rd_enb", ram_rd_enb, p_rd);
    check_eq("ram_addr", ram_addr, p_addr);
    check_eq("ram_din", ram_din, p_din);
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      r = rdq.pop_front();
      check_eq("rvalid_a", rvalid_a, r.own == 0);
      check_eq("rvalid_b", rvalid_b, r.own == 1);
      check_eq("rdata", rdata, r.data);
    end else begin
      check_eq("rvalid_a_idle", rvalid_a, 0);
      check_eq("rvalid_b_idle", rvalid_b, 0);
    end

    exp_g = '0;
    p_wr  = 1'b0;
    p_rd  = 1'b0;
    if (w >= 0) begin
      exp_g[w] = 1'b1;
      last_win = w;
      t_we = (w == 0) ? we_a : we_b;
      t_ad = (w == 0) ? addr_a : addr_b;
      t_wd = (w == 0) ? wdata_a : wdata_b;
      p_wr   = t_we;
      p_rd   = !t_we;
      p_addr = t_ad;
      p_din  = t_wd;
      if (t_we) mem_m[t_ad] = t_wd;
      else rdq.push_back('{due: cyc + 2, own: w, data: mem_m[t_ad]});
    end
    if (in_clear) foreach (mem_m[i]) mem_m[i] = '0;
    if (in_init)       in_init  = 1'b0;
    else if (in_clear) in_clear = 1'b0;
    else if (clr_req)  in_clear = 1'b1;
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".ram_rst"}, ram_rst, 1);
    check_eq({tag, ".ram_wr_enb"}, ram_wr_enb, 0);
    check_eq({tag, ".ram_rd_enb"}, ram_rd_enb, 0);
    check_eq({tag, ".ram_addr"}, ram_addr, 0);
    check_eq({tag, ".ram_din"}, ram_din, 0);
    check_eq({tag, ".rvalid_a"}, rvalid_a, 0);
    check_eq({tag, ".rvalid_b"}, rvalid_b, 0);
    check_eq({tag, ".clr_ack"}, clr_ack, 0);
    check_eq({tag, ".gnt_a"}, gnt_a, 0);
    check_eq({tag, ".gnt_b"}, gnt_b, 0);
  endtask

  // Called just after a rising edge; leaves the bench at the start of INIT.
  task automatic do_reset(input int hold_cycles);
    rst_n   = 1'b0;
    req_a   = 1'b1;
    req_b   = 1'b1;
    clr_req = 1'b0;
    #1;
    check_reset_state("rst_async");
    repeat (hold_cycles) begin
      @(negedge clock);
      check_reset_state("rst_hold");
    end
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clock);
    #1;
    do_reset(2);

    // Read of address 5 held from INIT; granted in the first RUN cycle.
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd5;
    cycle();
    cycle();
    we_a = 1'b1; addr_a = 4'd3; wdata_a = 8'hA5;
    cycle();
    we_a = 1'b0; addr_a = 4'd3;
    cycle();
    req_a = 1'b0;
    req_b = 1'b1; we_b = 1'b1; addr_b = 4'd7; wdata_b = 8'h3C;
    cycle();

    // Both requesting continuously: grants alternate.
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd3;
    we_b = 1'b0; addr_b = 4'd7;
    repeat (6) cycle();

    // Clear command alongside a held read of address 3.
    req_b = 1'b0;
    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    cycle();
    cycle();
    req_a = 1'b0;
    repeat (3) cycle();

    // Reset arrives one cycle after a read grant.
    req_a = 1'b1; we_a = 1'b0; addr_a = 4'd7;
    cycle();
    req_a = 1'b0;
    do_reset(3);
    repeat (3) cycle();

    for (int k = 0; k < 1500; k++) begin
      if (!req_a || exp_g[0]) begin
        req_a   = ($urandom_range(0, 3) != 0);
        we_a    = $urandom_range(0, 1) == 1;
        addr_a  = AW'($urandom_range(0, 2**AW - 1));
        wdata_a = DW'($urandom);
      end
      if (!req_b || exp_g[1]) begin
        req_b   = ($urandom_range(0, 3) != 0);
        we_b    = $urandom_range(0, 1) == 1;
        addr_b  = AW'($urandom_range(0, 2**AW - 1));
        wdata_b = DW'($urandom);
      end
      clr_req = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 300) == 0) do_reset(2);
      cycle();
    end

    req_a = 1'b0;
    req_b = 1'b0;
    clr_req = 1'b0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
